// File: rtl/sync_fifo_flex.sv
// sync_fifo_flex: single-clock FIFO with registered or first-word-fall-through read,
// programmable almost-full/almost-empty thresholds, flush and sticky error flags.
//
// Ports:
//   i_clk           rising-edge clock
//   i_rst           synchronous active-high reset
//   i_flush         synchronous empty request (memory and error flags kept)
//   i_wr_en/i_wr_data   write request and data
//   i_rd_en         read request (pop in FWFT mode)
//   i_clr_err       clears o_overflow/o_underflow
//   o_rd_data/o_rd_valid  read data and its qualifier
//   o_full, o_empty, o_almost_full, o_almost_empty  status decoded from o_count
//   o_count         occupancy 0..FIFO_DEPTH
//   o_overflow, o_underflow  sticky error flags
module sync_fifo_flex #(
    parameter int unsigned DATA_WIDTH   = 4,
    parameter int unsigned FIFO_DEPTH   = 8,
    parameter int unsigned AFULL_LEVEL  = 6,
    parameter int unsigned AEMPTY_LEVEL = 2,
    parameter int unsigned FWFT         = 0
) (
    input  logic                            i_clk,
    input  logic                            i_rst,
    input  logic                            i_flush,
    input  logic                            i_wr_en,
    input  logic [DATA_WIDTH-1:0]           i_wr_data,
    input  logic                            i_rd_en,
    input  logic                            i_clr_err,
    output logic [DATA_WIDTH-1:0]           o_rd_data,
    output logic                            o_rd_valid,
    output logic                            o_full,
    output logic                            o_empty,
    output logic                            o_almost_full,
    output logic                            o_almost_empty,
    output logic [$clog2(FIFO_DEPTH):0]     o_count,
    output logic                            o_overflow,
    output logic                            o_underflow
);

    localparam int unsigned PTR_WIDTH = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW      = PTR_WIDTH + 1;

    localparam logic [PTR_WIDTH:0] One     = CntW'(1);
    localparam logic [PTR_WIDTH:0] DepthC  = CntW'(FIFO_DEPTH);
    localparam logic [PTR_WIDTH:0] AfullC  = CntW'(AFULL_LEVEL);
    localparam logic [PTR_WIDTH:0] AemptyC = CntW'(AEMPTY_LEVEL);

    // Elaboration-time parameter range checks
    if (DATA_WIDTH < 1) begin : g_bad_width
        $error("DATA_WIDTH must be >= 1");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("FIFO_DEPTH must be a power of two >= 2");
    end
    if (AFULL_LEVEL < 1 || AFULL_LEVEL > FIFO_DEPTH) begin : g_bad_afull
        $error("AFULL_LEVEL must be in 1..FIFO_DEPTH");
    end
    if (AEMPTY_LEVEL > FIFO_DEPTH - 1) begin : g_bad_aempty
        $error("AEMPTY_LEVEL must be in 0..FIFO_DEPTH-1");
    end
    if (FWFT > 1) begin : g_bad_fwft
        $error("FWFT must be 0 or 1");
    end

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];

    logic [PTR_WIDTH:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_WIDTH:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_WIDTH:0]   count_q, count_d;
    logic                 ovf_q, ovf_d;
    logic                 unf_q, unf_d;
    logic                 full, empty;
    logic                 wr_accept, rd_accept;
    logic [PTR_WIDTH-1:0] wr_addr, rd_addr;

    assign full    = (count_q == DepthC);
    assign empty   = (count_q == '0);
    assign wr_addr = wr_ptr_q[PTR_WIDTH-1:0];
    assign rd_addr = rd_ptr_q[PTR_WIDTH-1:0];

    // Accept decisions use pre-edge flags, so a write at full is dropped even with a read
    assign wr_accept = i_wr_en && !full;
    assign rd_accept = i_rd_en && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (i_flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (wr_accept) wr_ptr_d = wr_ptr_q + One;
            if (rd_accept) rd_ptr_d = rd_ptr_q + One;
            if (wr_accept && !rd_accept) begin
                count_d = count_q + One;
            end else if (rd_accept && !wr_accept) begin
                count_d = count_q - One;
            end
        end

        // Set condition takes priority over clear
        ovf_d = ovf_q;
        unf_d = unf_q;
        if (i_clr_err) begin
            ovf_d = 1'b0;
            unf_d = 1'b0;
        end
        if (i_wr_en && full)  ovf_d = 1'b1;
        if (i_rd_en && empty) unf_d = 1'b1;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

    // Storage is not reset
    always_ff @(posedge i_clk) begin
        if (!i_rst && !i_flush && wr_accept) begin
            mem[wr_addr] <= i_wr_data;
        end
    end

    if (FWFT != 0) begin : g_fwft
        assign o_rd_data  = mem[rd_addr];
        assign o_rd_valid = !empty;
    end else begin : g_reg
        logic [DATA_WIDTH-1:0] rd_data_q;
        logic                  rd_valid_q;

        always_ff @(posedge i_clk) begin
            if (i_rst) begin
                rd_data_q  <= '0;
                rd_valid_q <= 1'b0;
            end else begin
                rd_valid_q <= rd_accept && !i_flush;
                if (rd_accept && !i_flush) begin
                    rd_data_q <= mem[rd_addr];
                end
            end
        end

        assign o_rd_data  = rd_data_q;
        assign o_rd_valid = rd_valid_q;
    end

    assign o_count        = count_q;
    assign o_full         = full;
    assign o_empty        = empty;
    assign o_almost_full  = (count_q >= AfullC);
    assign o_almost_empty = (count_q <= AemptyC);
    assign o_overflow     = ovf_q;
    assign o_underflow    = unf_q;

endmodule

// File: tb/tb_sync_fifo_flex.sv
// Bench for sync_fifo_flex: a registered-read and an FWFT instance share one stimulus
// stream and are both checked every cycle against a queue-based reference model.
module tb_sync_fifo_flex;

    localparam int Depth = 8;

    logic       clk = 1'b0;
    logic       rst, flush, wr_en, rd_en, clr_err;
    logic [3:0] wr_data;

    logic [3:0] r_rd_data, f_rd_data;
    logic       r_rd_valid, f_rd_valid;
    logic       r_full, r_empty, r_afull, r_aempty, r_ovf, r_unf;
    logic       f_full, f_empty, f_afull, f_aempty, f_ovf, f_unf;
    logic [3:0] r_count, f_count;

    always #5 clk = ~clk;

    sync_fifo_flex #(.FWFT(0)) u_reg (
        .i_clk(clk), .i_rst(rst), .i_flush(flush), .i_wr_en(wr_en), .i_wr_data(wr_data),
        .i_rd_en(rd_en), .i_clr_err(clr_err), .o_rd_data(r_rd_data), .o_rd_valid(r_rd_valid),
        .o_full(r_full), .o_empty(r_empty), .o_almost_full(r_afull),
        .o_almost_empty(r_aempty), .o_count(r_count), .o_overflow(r_ovf),
        .o_underflow(r_unf)
    );

    sync_fifo_flex #(.FWFT(1)) u_fwft (
        .i_clk(clk), .i_rst(rst), .i_flush(flush), .i_wr_en(wr_en), .i_wr_data(wr_data),
        .i_rd_en(rd_en), .i_clr_err(clr_err), .o_rd_data(f_rd_data), .o_rd_valid(f_rd_valid),
        .o_full(f_full), .o_empty(f_empty), .o_almost_full(f_afull),
        .o_almost_empty(f_aempty), .o_count(f_count), .o_overflow(f_ovf),
        .o_underflow(f_unf)
    );

    int n_vec = 0;
    int n_err = 0;
    int n_cmp = 0;

    // Reference model: contents as a queue plus the registered-read output state
    logic [3:0] q[$];
    bit         m_rdv;
    logic [3:0] m_rdd;
    bit         m_ovf, m_unf;

    function automatic void chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endfunction

    function automatic void model_edge(input bit r, fl, w, input logic [3:0] wd,
                                       input bit rd, clr);
        bit was_full, was_empty;
        if (r) begin
            q.delete();
            m_rdv = 0; m_rdd = 4'd0; m_ovf = 0; m_unf = 0;
            return;
        end
        was_full  = (q.size() == Depth);
        was_empty = (q.size() == 0);
        if (w && was_full)       m_ovf = 1;
        else if (clr)            m_ovf = 0;
        if (rd && was_empty)     m_unf = 1;
        else if (clr)            m_unf = 0;
        if (fl) begin
            q.delete();
            m_rdv = 0;
        end else begin
            m_rdv = rd && !was_empty;
            if (m_rdv) m_rdd = q.pop_front();
            if (w && !was_full) q.push_back(wd);
        end
    endfunction

    task automatic compare_all();
        int c;
        c = q.size();
        chk("count",  int'(r_count),    c);
        chk("full",   int'(r_full),     int'(c == Depth));
        chk("empty",  int'(r_empty),    int'(c == 0));
        chk("afull",  int'(r_afull),    int'(c >= 6));
        chk("aempty", int'(r_aempty),   int'(c <= 2));
        chk("rd_valid", int'(r_rd_valid), int'(m_rdv));
        chk("rd_data",  int'(r_rd_data),  int'(m_rdd));
        chk("overflow",  int'(r_ovf), int'(m_ovf));
        chk("underflow", int'(r_unf), int'(m_unf));
        chk("f_count",   int'(f_count),    c);
        chk("f_flags",   int'({f_full, f_empty, f_afull, f_aempty}),
            int'({c == Depth, c == 0, c >= 6, c <= 2}));
        chk("f_rd_valid", int'(f_rd_valid), int'(c != 0));
        if (c != 0) chk("f_rd_data", int'(f_rd_data), int'(q[0]));
        chk("f_err", int'({f_ovf, f_unf}), int'({m_ovf, m_unf}));
    endtask

    task automatic step(input bit r, fl, w, input logic [3:0] wd, input bit rd, clr);
        rst = r; flush = fl; wr_en = w; wr_data = wd; rd_en = rd; clr_err = clr;
        @(posedge clk);
        model_edge(r, fl, w, wd, rd, clr);
        #1;
        n_vec++;
        compare_all();
    endtask

    typedef struct {
        bit         rst, flush, wr;
        logic [3:0] wd;
        bit         rd, clr;
        int         cnt;
        bit         rdv;
        logic [3:0] rdd;
        bit         ovf, unf;
    } vec_t;

    vec_t tbl[21];

    function automatic vec_t mk(input bit r, fl, w, input logic [3:0] wd, input bit rd, clr,
                                input int cnt, input bit rdv, input logic [3:0] rdd,
                                input bit ovf, unf);
        vec_t v;
        v.rst = r; v.flush = fl; v.wr = w; v.wd = wd; v.rd = rd; v.clr = clr;
        v.cnt = cnt; v.rdv = rdv; v.rdd = rdd; v.ovf = ovf; v.unf = unf;
        return v;
    endfunction

    initial begin
        rst = 1; flush = 0; wr_en = 0; wr_data = 0; rd_en = 0; clr_err = 0;

        // Fill 1..8, overflow, clear, drain 1..8, underflow, clear
        tbl[0] = mk(1, 0, 0, 4'd0, 0, 0, 0, 0, 4'd0, 0, 0);
        for (int i = 1; i <= 8; i++) tbl[i] = mk(0, 0, 1, 4'(i), 0, 0, i, 0, 4'd0, 0, 0);
        tbl[9]  = mk(0, 0, 1, 4'd9, 0, 0, 8, 0, 4'd0, 1, 0);
        tbl[10] = mk(0, 0, 0, 4'd0, 0, 1, 8, 0, 4'd0, 0, 0);
        for (int i = 1; i <= 8; i++) tbl[10+i] = mk(0, 0, 0, 4'd0, 1, 0, 8-i, 1, 4'(i), 0, 0);
        tbl[19] = mk(0, 0, 0, 4'd0, 1, 0, 0, 0, 4'd8, 0, 1);
        tbl[20] = mk(0, 0, 0, 4'd0, 0, 1, 0, 0, 4'd8, 0, 0);

        for (int i = 0; i < 21; i++) begin
            step(tbl[i].rst, tbl[i].flush, tbl[i].wr, tbl[i].wd, tbl[i].rd, tbl[i].clr);
            chk($sformatf("tbl%0d_count", i), int'(r_count), tbl[i].cnt);
            chk($sformatf("tbl%0d_full", i),  int'(r_full),  int'(tbl[i].cnt == 8));
            chk($sformatf("tbl%0d_afull", i), int'(r_afull), int'(tbl[i].cnt >= 6));
            chk($sformatf("tbl%0d_empty", i), int'(r_empty), int'(tbl[i].cnt == 0));
            chk($sformatf("tbl%0d_rdv", i),   int'(r_rd_valid), int'(tbl[i].rdv));
            chk($sformatf("tbl%0d_rdd", i),   int'(r_rd_data),  int'(tbl[i].rdd));
            chk($sformatf("tbl%0d_ovf", i),   int'(r_ovf), int'(tbl[i].ovf));
            chk($sformatf("tbl%0d_unf", i),   int'(r_unf), int'(tbl[i].unf));
        end

        // Count 4, then 10 cycles of simultaneous write/read across the pointer wrap
        for (int i = 0; i < 4; i++) step(0, 0, 1, 4'(4'hC + i), 0, 0);
        for (int i = 0; i < 10; i++) begin
            step(0, 0, 1, 4'(i), 1, 0);
            chk("wrap_count", int'(r_count), 4);
        end
        chk("wrap_last_rdd", int'(r_rd_data), 5);

        // FWFT: word into empty FIFO visible the next cycle without a read
        step(1, 0, 0, 4'd0, 0, 0);
        step(0, 0, 1, 4'hA, 0, 0);
        chk("fwft_valid", int'(f_rd_valid), 1);
        chk("fwft_data",  int'(f_rd_data), 10);
        step(0, 0, 0, 4'd0, 1, 0);
        chk("fwft_pop_empty", int'(f_empty), 1);
        chk("fwft_pop_rdd", int'(r_rd_data), 10);

        // Overflow set wins over same-cycle clear; flush with write keeps the flag
        for (int i = 0; i < 8; i++) step(0, 0, 1, 4'(i + 3), 0, 0);
        step(0, 0, 1, 4'hF, 0, 1);
        chk("set_wins_ovf", int'(r_ovf), 1);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 4'd0, 1, 0);
        chk("pre_flush_count", int'(r_count), 5);
        step(0, 1, 1, 4'h7, 0, 0);
        chk("flush_count", int'(r_count), 0);
        chk("flush_empty", int'(r_empty), 1);
        chk("flush_ovf",   int'(r_ovf), 1);
        chk("flush_rdv",   int'(r_rd_valid), 0);
        step(0, 0, 0, 4'd0, 0, 1);
        chk("clr_ovf", int'(r_ovf), 0);

        // Mid-stream reset with a write pending
        for (int i = 0; i < 3; i++) step(0, 0, 1, 4'(i + 1), 0, 0);
        step(0, 0, 0, 4'd0, 1, 0);
        step(1, 0, 1, 4'h9, 1, 0);
        chk("rst_count", int'(r_count), 0);
        chk("rst_flags", int'({r_empty, r_full, r_aempty, r_afull}), 4'b1010);
        chk("rst_rd",    int'({r_rd_valid, r_rd_data}), 0);
        chk("rst_err",   int'({r_ovf, r_unf}), 0);

        // Randomized traffic with drifting write/read bias
        for (int i = 0; i < 1200; i++) begin
            int wb;
            wb = ((i / 150) % 2 == 0) ? 75 : 25;
            step($urandom_range(0, 199) == 0, $urandom_range(0, 79) == 0,
                 $urandom_range(0, 99) < wb, 4'($urandom), $urandom_range(0, 99) < 100 - wb,
                 $urandom_range(0, 29) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/sync_fifo_flex.md
SYNC_FIFO_FLEX -- requirements
Module: sync_fifo_flex

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 4: width of each stored word.
REQ-002 SHALL have parameter FIFO_DEPTH, default 8: number of entries; power of two, >=2.
REQ-003 SHALL have parameter AFULL_LEVEL, default 6: almost-full threshold; range 1..FIFO_DEPTH.
REQ-004 SHALL have parameter AEMPTY_LEVEL, default 2: almost-empty threshold; range 0..FIFO_DEPTH-1.
REQ-005 SHALL have parameter FWFT, default 0: 0 = registered-read mode, 1 = first-word-fall-through mode.
REQ-006 SHALL derive localparam PTR_WIDTH = $clog2(FIFO_DEPTH).
REQ-007 SHALL fail elaboration on any parameter outside its stated range.
REQ-008 Port i_clk, input, 1: the single clock; all logic on its rising edge.
REQ-009 Port i_rst, input, 1: reset, synchronous and active-high.
REQ-010 Port i_flush, input, 1: synchronous empty request.
REQ-011 Port i_wr_en, input, 1: write request.
REQ-012 Port i_wr_data, input, DATA_WIDTH: write data.
REQ-013 Port i_rd_en, input, 1: read request (pop in FWFT mode).
REQ-014 Port i_clr_err, input, 1: clears the sticky error flags.
REQ-015 Port o_rd_data, output, DATA_WIDTH: read data.
REQ-016 Port o_rd_valid, output, 1: o_rd_data is valid.
REQ-017 Port o_full, output, 1; o_empty, output, 1; o_almost_full, output, 1; o_almost_empty, output, 1: status flags.
REQ-018 Port o_count, output, PTR_WIDTH+1: current occupancy, range 0..FIFO_DEPTH.
REQ-019 Port o_overflow, output, 1; o_underflow, output, 1: sticky error flags.

Function
REQ-020 SHALL use PTR_WIDTH+1-bit binary wr/rd pointers that wrap naturally; storage address = low PTR_WIDTH bits.
REQ-021 SHALL accept a write iff i_wr_en && !o_full; accepted data goes to mem[wr_addr] and wr_ptr increments.
REQ-022 SHALL accept a read iff i_rd_en && !o_empty; rd_ptr increments.
REQ-023 SHALL register o_count: +1 on write only, -1 on read only, unchanged on both or neither.
REQ-024 SHALL drive o_full = (o_count==FIFO_DEPTH), o_empty = (o_count==0), o_almost_full = (o_count>=AFULL_LEVEL), o_almost_empty = (o_count<=AEMPTY_LEVEL), all decoded from the registered count.
REQ-025 SHALL NOT pass a write through at full even if a read occurs in the same cycle; write is dropped.
REQ-026 FWFT=0: an accepted read SHALL load o_rd_data with mem[rd_addr] at that edge; o_rd_valid SHALL be 1 for exactly the following cycle; o_rd_data SHALL hold its last value otherwise.
REQ-027 FWFT=1: o_rd_data SHALL equal mem[rd_addr] combinationally and o_rd_valid = !o_empty; a word written into an empty FIFO SHALL appear the cycle after its write edge.
REQ-028 o_overflow SHALL set on i_wr_en && o_full; o_underflow SHALL set on i_rd_en && o_empty.
REQ-029 Error flags SHALL persist until i_clr_err; a set condition in the same cycle as i_clr_err SHALL win.
REQ-030 i_flush SHALL zero both pointers and o_count at the edge, ignore any same-cycle read/write, and clear o_rd_valid; memory contents and error flags SHALL be untouched.

Reset
REQ-031 i_rst high at a clock edge SHALL force o_count=0, o_empty=1, o_full=0, o_almost_empty=1, o_almost_full=0, o_rd_valid=0, o_rd_data=0 (FWFT=0), o_overflow=0, o_underflow=0, pointers=0.
REQ-032 Reset SHALL override i_flush, i_wr_en, i_rd_en and i_clr_err; memory array SHALL NOT be reset.

Verification
REQ-033 Defaults, FWFT=0: write 1..8 on consecutive cycles -> o_count=8, o_full=1, o_almost_full=1 from count 6; a 9th write -> o_overflow=1 and o_count stays 8.
REQ-034 FWFT=0, read 8 times -> o_rd_data 1..8, each valid one cycle after its i_rd_en; a further read -> o_underflow=1 and o_empty=1.
REQ-035 Count 4, simultaneous i_wr_en/i_rd_en for 10 cycles -> o_count stays 4; data order preserved across pointer wrap.
REQ-036 FWFT=1, write 0xA to an empty FIFO -> next cycle o_rd_valid=1 and o_rd_data=0xA without i_rd_en; pop -> o_empty=1.
REQ-037 Count 5 with o_overflow set: assert i_flush with i_wr_en -> o_count=0, o_empty=1, o_overflow still 1; i_clr_err -> o_overflow=0.
REQ-038 Mid-stream i_rst with i_wr_en=1 -> all outputs at REQ-031 values the next cycle; the same-cycle write is discarded.
